// File: rtl/branch_predict_unit.sv
// Direction predictor for the fetch stage. It keeps a direct-mapped, untagged table of
// 2-bit saturating counters. Each branch is looked up in one cycle and trained in the next.
module branch_predict_unit #(
  parameter int N           = 32,
  parameter int TABLE_DEPTH = 256,
  parameter int INDEX_WIDTH = $clog2(TABLE_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_is_branch,
  input  logic [N-1:0] i_branch_pc,
  input  logic [N-1:0] i_offset_pc,
  input  logic         i_actually_taken,
  output logic         o_prediction,
  output logic [N-1:0] o_predicted_pc
);

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  cnt_e                   cnt_q [TABLE_DEPTH];
  logic                   pend_valid_q;
  logic [INDEX_WIDTH-1:0] pend_idx_q;
  logic [N-1:0]           pend_pc_q;
  logic                   pend_pred_q;

  logic [INDEX_WIDTH-1:0] lookup_idx;
  cnt_e                   upd_cnt_d;
  cnt_e                   rd_cnt;
  logic                   unused_pc_bits;

  // The low two PC bits and the bits above the index do not take part in the lookup.
  assign lookup_idx     = i_branch_pc[INDEX_WIDTH+1:2];
  assign unused_pc_bits = ^{i_branch_pc[N-1:INDEX_WIDTH+2], i_branch_pc[1:0]};

  // NOTE: every variable written in always_comb gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    upd_cnt_d = cnt_q[pend_idx_q];
    if (i_actually_taken) begin
      if (cnt_q[pend_idx_q] != CNT_ST) upd_cnt_d = cnt_e'(cnt_q[pend_idx_q] + 2'd1);
    end else begin
      if (cnt_q[pend_idx_q] != CNT_SNT) upd_cnt_d = cnt_e'(cnt_q[pend_idx_q] - 2'd1);
    end
  end

  // A lookup that meets a training write to the same entry on the same edge
  // sees the trained value.
  always_comb begin
    rd_cnt = cnt_q[lookup_idx];
    if (pend_valid_q && (pend_idx_q == lookup_idx)) rd_cnt = upd_cnt_d;
  end

  // NOTE: the counter table is built from flops rather than RAM, because every entry
  // must return to WNT on reset. A RAM macro could not be cleared in one cycle.
  // NOTE: sequential state uses non-blocking assignments only, so that every read on
  // this edge sees the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) cnt_q[i] <= CNT_WNT;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
      pend_pc_q    <= '0;
      pend_pred_q  <= 1'b0;
    end else begin
      if (pend_valid_q) cnt_q[pend_idx_q] <= upd_cnt_d;
      pend_valid_q <= i_is_branch;
      if (i_is_branch) begin
        pend_idx_q  <= lookup_idx;
        pend_pc_q   <= i_branch_pc;
        pend_pred_q <= rd_cnt[1];
      end
    end
  end

  always_comb begin
    o_prediction   = pend_valid_q & pend_pred_q;
    o_predicted_pc = '0;
    if (pend_valid_q) o_predicted_pc = pend_pred_q ? i_offset_pc : pend_pc_q + N'(4);
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit. The expected predictions are worked out by hand
// from the counter history of each table entry.
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_is_branch;
  logic [31:0] i_branch_pc;
  logic [31:0] i_offset_pc;
  logic        i_actually_taken;
  logic        o_prediction;
  logic [31:0] o_predicted_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] off;
    logic        taken;
    logic        exp_pred;
    logic [31:0] exp_pc;
  } vec_t;

  branch_predict_unit dut (
    .clk              (clk),
    .rst              (rst),
    .i_is_branch      (i_is_branch),
    .i_branch_pc      (i_branch_pc),
    .i_offset_pc      (i_offset_pc),
    .i_actually_taken (i_actually_taken),
    .o_prediction     (o_prediction),
    .o_predicted_pc   (o_predicted_pc)
  );

  always #5 clk = ~clk;

  // Present a branch for one edge, then drive its resolution. This task only drives
  // stimulus. It returns with the branch pending, 2 time units after the edge.
  task automatic branch_cycle(input logic [31:0] pc, input logic [31:0] off, input logic taken);
    i_is_branch = 1'b1;
    i_branch_pc = pc;
    @(posedge clk);
    #1;
    i_is_branch      = 1'b0;
    i_branch_pc      = 32'hBAAD_F00D;
    i_offset_pc      = off;
    i_actually_taken = taken;
    #1;
  endtask

  task automatic run_vectors(input string name, input vec_t v[]);
    for (int i = 0; i < v.size(); i++) begin
      branch_cycle(v[i].pc, v[i].off, v[i].taken);
      checks++;
      if (o_prediction !== v[i].exp_pred) begin
        errors++;
        $display("FAIL %s[%0d] prediction: got %b expected %b", name, i, o_prediction, v[i].exp_pred);
      end
      checks++;
      if (o_predicted_pc !== v[i].exp_pc) begin
        errors++;
        $display("FAIL %s[%0d] predicted_pc: got %h expected %h", name, i, o_predicted_pc, v[i].exp_pc);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; i_is_branch = 1'b0; i_branch_pc = '0;
    i_offset_pc = 32'hFFFF_FFFF; i_actually_taken = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (o_prediction !== 1'b0) begin
      errors++; $display("FAIL reset prediction: got %b expected 0", o_prediction);
    end
    checks++;
    if (o_predicted_pc !== 32'h0) begin
      errors++; $display("FAIL reset predicted_pc: got %h expected 0", o_predicted_pc);
    end
  endtask

  // Entry 4 goes WNT, then SNT, stays at SNT, and then climbs back to WT.
  task automatic test_not_taken_saturate;
    vec_t v[] = '{
      '{32'h10, 32'h20, 1'b0, 1'b0, 32'h14},
      '{32'h10, 32'h20, 1'b0, 1'b0, 32'h14},
      '{32'h10, 32'h20, 1'b1, 1'b0, 32'h14},
      '{32'h10, 32'h20, 1'b1, 1'b0, 32'h14},
      '{32'h10, 32'h20, 1'b1, 1'b1, 32'h20}
    };
    run_vectors("not_taken_saturate", v);
  endtask

  // Entry 5 goes WNT, then WT, then ST, and stays at ST.
  task automatic test_taken_saturate;
    vec_t v[] = '{
      '{32'h14, 32'h28, 1'b1, 1'b0, 32'h18},
      '{32'h14, 32'h28, 1'b1, 1'b1, 32'h28},
      '{32'h14, 32'h28, 1'b1, 1'b1, 32'h28},
      '{32'h14, 32'h28, 1'b1, 1'b1, 32'h28}
    };
    run_vectors("taken_saturate", v);
  endtask

  // First encounters predict not-taken. PC+4 wraps at the top of the address space.
  task automatic test_new_pcs;
    vec_t v[] = '{
      '{32'h18,        32'h100, 1'b0, 1'b0, 32'h1C},
      '{32'h1C,        32'h100, 1'b0, 1'b0, 32'h20},
      '{32'hFFFF_FFFC, 32'h100, 1'b0, 1'b0, 32'h0},
      '{32'h20,        32'h100, 1'b0, 1'b0, 32'h24}
    };
    run_vectors("new_pcs", v);
  endtask

  // Idle cycles give zero outputs and must not train the stale pending index (entry 8).
  task automatic test_non_branch;
    vec_t v[] = '{'{32'h20, 32'h30, 1'b0, 1'b0, 32'h24}};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      i_offset_pc      = 32'hDEAD_BEEF;
      i_actually_taken = 1'b1;
      #1;
      checks++;
      if (o_prediction !== 1'b0) begin
        errors++; $display("FAIL non_branch[%0d] prediction: got %b expected 0", i, o_prediction);
      end
      checks++;
      if (o_predicted_pc !== 32'h0) begin
        errors++; $display("FAIL non_branch[%0d] predicted_pc: got %h expected 0", i, o_predicted_pc);
      end
    end
    run_vectors("non_branch_after", v);
  endtask

  // 0x14 and 0x414 alias to entry 5. Each lookup reads the count that the previous
  // branch writes on the same edge.
  task automatic test_back_to_back;
    vec_t v[] = '{
      '{32'h14,  32'h28,  1'b0, 1'b1, 32'h28},
      '{32'h414, 32'h500, 1'b0, 1'b1, 32'h500},
      '{32'h14,  32'h600, 1'b1, 1'b0, 32'h18},
      '{32'h14,  32'h28,  1'b1, 1'b1, 32'h28}
    };
    run_vectors("back_to_back", v);
  endtask

  // Entry 5 is WT, and a taken resolution is pending. Reset must drop it and restore WNT.
  task automatic test_reset_mid;
    vec_t v[] = '{'{32'h14, 32'h28, 1'b1, 1'b0, 32'h18}};
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (o_prediction !== 1'b0) begin
      errors++; $display("FAIL reset_mid prediction: got %b expected 0", o_prediction);
    end
    checks++;
    if (o_predicted_pc !== 32'h0) begin
      errors++; $display("FAIL reset_mid predicted_pc: got %h expected 0", o_predicted_pc);
    end
    run_vectors("reset_mid_after", v);
  endtask

  initial begin
    test_reset();
    test_not_taken_saturate();
    test_taken_saturate();
    test_new_pcs();
    test_non_branch();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
